// File: rtl/byte_stream_packer.sv
// Packs a valid/ready byte stream into OUTPUT_BYTES-wide words with selectable
// byte order, per-lane keep and a last flag; s_last flushes a short word.
module byte_stream_packer #(
    parameter int unsigned BYTE_SIZE    = 8,
    parameter int unsigned OUTPUT_BYTES = 4,
    parameter bit          BIG_ENDIAN   = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [BYTE_SIZE-1:0]              s_data,
    input  logic                              s_valid,
    input  logic                              s_last,
    output logic                              s_ready,
    output logic [OUTPUT_BYTES*BYTE_SIZE-1:0] m_data,
    output logic [OUTPUT_BYTES-1:0]           m_keep,
    output logic                              m_last,
    output logic                              m_valid,
    input  logic                              m_ready
);

    localparam int unsigned DW = OUTPUT_BYTES * BYTE_SIZE;
    localparam int unsigned CW = $clog2(OUTPUT_BYTES);
    localparam logic [CW-1:0] LAST_CNT = CW'(OUTPUT_BYTES - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           lane;
    logic [DW-1:0]           acc_q, acc_d, acc_wr;
    logic [OUTPUT_BYTES-1:0] keep_q, keep_d, keep_wr;
    logic [DW-1:0]           m_data_q, m_data_d;
    logic [OUTPUT_BYTES-1:0] m_keep_q, m_keep_d;
    logic                    m_last_q, m_last_d;
    logic                    m_valid_q, m_valid_d;
    logic                    accept;
    logic                    complete;

    // A pending word that is not being taken blocks the input.
    assign s_ready  = !m_valid_q || m_ready;
    assign accept   = s_valid && s_ready;
    assign complete = accept && ((cnt_q == LAST_CNT) || s_last);
    assign lane     = BIG_ENDIAN ? (LAST_CNT - cnt_q) : cnt_q;

    // Accumulator and keep with the incoming byte merged into its lane.
    always_comb begin
        acc_wr  = acc_q;
        keep_wr = keep_q;
        for (int k = 0; k < int'(OUTPUT_BYTES); k++) begin
            if (lane == CW'(k)) begin
                acc_wr[k*BYTE_SIZE +: BYTE_SIZE] = s_data;
                keep_wr[k]                       = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        keep_d    = keep_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
        m_valid_d = m_valid_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (complete) begin
            m_data_d  = acc_wr;
            m_keep_d  = keep_wr;
            m_last_d  = s_last;
            m_valid_d = 1'b1;
            acc_d     = '0;
            keep_d    = '0;
            cnt_d     = '0;
        end else if (accept) begin
            acc_d  = acc_wr;
            keep_d = keep_wr;
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            keep_q    <= '0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            keep_q    <= keep_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;
    assign m_valid = m_valid_q;

endmodule
